// File: rtl/rx_sample_buf_pkg.sv
`timescale 1ns/1ps
// rx_sample_buf_pkg
// Shared definitions for the decimated I/Q sample buffer:
//   - default sample width and output word width
//   - bit positions of the I and Q fields inside a stored {I,Q} pair
//   - word sequencer state encodings (W0/W1/W2)
//   - pack_word(): selects the 16-bit output word for a given sequencer state
package rx_sample_buf_pkg;

  localparam int SAMP_BITS_DEF = 24;
  localparam int RXO_BITS      = 16;
  localparam int PAIR_BITS     = 2 * SAMP_BITS_DEF;

  // A stored pair is {I[23:0], Q[23:0]}, so I occupies [47:24] and Q [23:0].
  localparam int I_HI_MSB = 47;
  localparam int I_HI_LSB = 32;
  localparam int I_LO_MSB = 31;
  localparam int I_LO_LSB = 24;
  localparam int Q_HI_MSB = 23;
  localparam int Q_HI_LSB = 8;
  localparam int Q_LO_MSB = 7;
  localparam int Q_LO_LSB = 0;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } word_sel_e;

  // W0 = I[23:8], W1 = Q[23:8], W2 = {I[7:0], Q[7:0]}
  function automatic logic [RXO_BITS-1:0] pack_word(input word_sel_e sel,
                                                    input logic [PAIR_BITS-1:0] pair);
    logic [RXO_BITS-1:0] w;
    case (sel)
      W0:      w = pair[I_HI_MSB:I_HI_LSB];
      W1:      w = pair[Q_HI_MSB:Q_HI_LSB];
      W2:      w = {pair[I_LO_MSB:I_LO_LSB], pair[Q_LO_MSB:Q_LO_LSB]};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rx_sample_buf_ram.sv
`timescale 1ns/1ps
// rx_sample_ram
// Simple dual-port sample storage: one synchronous write port, one read port
// with a registered output. No reset; contents are undefined until written.
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data ({I,Q} pair)
//   rd_addr  - read address, sampled every clock
//   rd_data  - registered read data (word at rd_addr as of the previous edge)
module rx_sample_ram
  import rx_sample_buf_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = PAIR_BITS
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [DATA_BITS-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_sample_buf.sv
`timescale 1ns/1ps
// rx_sample_buf
// FIFO of decimated {I,Q} samples, drained as a stream of 16-bit words
// (three words per sample, W0/W1/W2).
// Ports:
//   adc_clk    - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   in_strobe  - sample valid pulse; in_i/in_q are signed I/Q samples
//   clear      - synchronous flush, wins over in_strobe and rd_word
//   rd_word    - consumes the current dout word (ignored while dout_valid low)
//   thresh     - fill level at which ready asserts
//   dout       - current output word, zero while dout_valid is low
//   dout_valid - dout holds a real word
//   count      - samples stored
//   full/empty - fill flags derived from count
//   overflow   - sticky: a sample was dropped because the buffer was full
//   ready      - registered (count >= thresh)
module rx_sample_buf
  import rx_sample_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int SAMP_BITS  = SAMP_BITS_DEF
) (
  input  logic                        adc_clk,
  input  logic                        reset_n,
  input  logic                        in_strobe,
  input  logic signed [SAMP_BITS-1:0] in_i,
  input  logic signed [SAMP_BITS-1:0] in_q,
  input  logic                        clear,
  input  logic                        rd_word,
  input  logic [DEPTH_LOG2:0]         thresh,
  output logic [RXO_BITS-1:0]         dout,
  output logic                        dout_valid,
  output logic [DEPTH_LOG2:0]         count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  output logic                        ready
);

  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  word_sel_e             seq_q, seq_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  ready_q, ready_d;

  logic                   full_now;
  logic                   push;
  logic                   pop;
  logic [2*SAMP_BITS-1:0] rd_pair;

  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for a coincident push.
  assign full_now = (count_q == DEPTH_CNT);
  assign push     = in_strobe && !full_now && !clear;
  assign pop      = rd_word && valid_q && (seq_q == W2) && !clear;

  rx_sample_ram #(
    .ADDR_BITS (DEPTH_LOG2),
    .DATA_BITS (2*SAMP_BITS)
  ) u_ram (
    .clk     (adc_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_i, in_q}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_pair)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ready_d  = (count_q >= thresh);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      seq_d    = W0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (in_strobe && full_now) begin
        ovf_d = 1'b1;
      end

      if (rd_word && valid_q) begin
        case (seq_q)
          W0: seq_d = W1;
          W1: seq_d = W2;
          W2: begin
            seq_d    = W0;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
          default: seq_d = W0;
        endcase
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // The RAM output register loads the head on the same edge valid rises;
      // after a pop, one cycle is spent refilling from the new read pointer.
      if (pop) begin
        valid_d = 1'b0;
      end else if (!valid_q && (count_q != '0)) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= W0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
    end
  end

  assign dout       = valid_q ? pack_word(seq_q, rd_pair) : '0;
  assign dout_valid = valid_q;
  assign count      = count_q;
  assign full       = full_now;
  assign empty      = (count_q == '0);
  assign overflow   = ovf_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_rx_sample_buf.sv
`timescale 1ns/1ps
// tb_rx_sample_buf
// Scoreboard bench: each accepted push queues the three words it should yield;
// a monitor pops and compares whenever a word is consumed (rd_word with
// dout_valid). Flag and count checks use hand-computed constants.
module tb_rx_sample_buf;

  localparam int DEPTH = 256;

  logic               adc_clk = 1'b0;
  logic               reset_n;
  logic               in_strobe;
  logic signed [23:0] in_i;
  logic signed [23:0] in_q;
  logic               clear;
  logic               rd_word;
  logic [8:0]         thresh;
  logic [15:0]        dout;
  logic               dout_valid;
  logic [8:0]         count;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               ready;

  int          vectors     = 0;
  int          miscompares = 0;
  int          model_cnt   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  rx_sample_buf #(
    .DEPTH_LOG2 (8),
    .SAMP_BITS  (24)
  ) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .in_strobe  (in_strobe),
    .in_i       (in_i),
    .in_q       (in_q),
    .clear      (clear),
    .rd_word    (rd_word),
    .thresh     (thresh),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .ready      (ready)
  );

  // 100 MHz clock
  always #5 adc_clk = ~adc_clk;

  // Monitor: compares every consumed word against the scoreboard head.
  always @(negedge adc_clk) begin
    if (reset_n && rd_word && dout_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_extra_word: got dout=%h, expected no word pending", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          miscompares++;
          $display("[TB] FAIL sb_word: got dout=%h, expected %h", dout, mon_exp);
        end
      end
    end
  end

  // Hard stop if something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns the pulse inputs to idle.
  task automatic applyStimulus(input logic strobe, input logic [23:0] i, input logic [23:0] q,
                               input logic clr, input logic rd);
    in_strobe = strobe;
    in_i      = i;
    in_q      = q;
    clear     = clr;
    rd_word   = rd;
    tick();
    in_strobe = 1'b0;
    clear     = 1'b0;
    rd_word   = 1'b0;
  endtask

  task automatic pushSample(input logic [23:0] i, input logic [23:0] q);
    if (model_cnt < DEPTH) begin
      exp_q.push_back(i[23:8]);
      exp_q.push_back(q[23:8]);
      exp_q.push_back({i[7:0], q[7:0]});
      model_cnt++;
    end
    applyStimulus(1'b1, i, q, 1'b0, 1'b0);
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!dout_valid && n < 8) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(dout_valid), 32'd1);
  endtask

  task automatic readWords(input int n);
    repeat (n) applyStimulus(1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
  endtask

  task automatic readSample();
    waitValid("wait_valid");
    readWords(3);
    model_cnt--;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_strobe = 1'b0;
    in_i      = '0;
    in_q      = '0;
    clear     = 1'b0;
    rd_word   = 1'b0;
    thresh    = 9'd1;

    // Reset values
    #12;
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    tick();
    reset_n = 1'b1;

    // Single sample: latency and word packing
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h56EF);
    model_cnt++;
    applyStimulus(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
    checkOutput("t1_valid_cycle1", 32'(dout_valid), 32'd0);
    checkOutput("t1_dout_zero", 32'(dout), 32'h0);
    tick();
    checkOutput("t1_valid_cycle2", 32'(dout_valid), 32'd1);
    checkOutput("t1_count", 32'(count), 32'd1);
    checkOutput("t1_head_w0", 32'(dout), 32'h1234);
    readWords(3);
    model_cnt--;
    checkOutput("t1_valid_after_pop", 32'(dout_valid), 32'd0);
    checkOutput("t1_empty", 32'(empty), 32'd1);

    // 257 pushes into a 256-deep buffer
    for (int k = 0; k < 257; k++) begin
      pushSample(24'h100000 | 24'(k), 24'h800000 | 24'(k * 5));
    end
    checkOutput("t2_count", 32'(count), 32'd256);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_ovf", 32'(overflow), 32'd1);
    checkOutput("t2_empty", 32'(empty), 32'd0);
    repeat (256) readSample();
    checkOutput("t2_drained_empty", 32'(empty), 32'd1);
    checkOutput("t2_sb_left", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Full buffer: push coincident with a W2 pop is dropped
    exp_q.delete();
    model_cnt = 0;
    applyStimulus(1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    checkOutput("t3_ovf_cleared", 32'(overflow), 32'd0);
    for (int k = 0; k < 256; k++) begin
      pushSample(24'h200000 | 24'(k), 24'h400000 | 24'(k * 3));
    end
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_ovf_before", 32'(overflow), 32'd0);
    waitValid("t3_wait_valid");
    readWords(2);
    applyStimulus(1'b1, 24'hDEAD00, 24'hBEEF00, 1'b0, 1'b1);
    model_cnt--;
    checkOutput("t3_count", 32'(count), 32'd255);
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    checkOutput("t3_full_after", 32'(full), 32'd0);
    checkOutput("t3_refill", 32'(dout_valid), 32'd0);
    repeat (255) readSample();
    checkOutput("t3_drained_empty", 32'(empty), 32'd1);
    checkOutput("t3_sb_left", 32'(exp_q.size()), 32'd0);

    // Clear wins over a coincident push
    for (int k = 0; k < 10; k++) begin
      pushSample(24'h300000 | 24'(k), 24'h0A0000 | 24'(k));
    end
    checkOutput("t4_count_pre", 32'(count), 32'd10);
    exp_q.delete();
    model_cnt = 0;
    applyStimulus(1'b1, 24'h777777, 24'h777777, 1'b1, 1'b0);
    checkOutput("t4_count", 32'(count), 32'd0);
    checkOutput("t4_empty", 32'(empty), 32'd1);
    checkOutput("t4_ovf", 32'(overflow), 32'd0);
    checkOutput("t4_valid", 32'(dout_valid), 32'd0);
    tick();
    checkOutput("t4_valid_next", 32'(dout_valid), 32'd0);
    checkOutput("t4_count_next", 32'(count), 32'd0);

    // Ready threshold
    thresh = 9'd4;
    tick();
    checkOutput("t5_ready_empty", 32'(ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      pushSample(24'h400000 | 24'(k), 24'h050000 | 24'(k));
    end
    checkOutput("t5_count4", 32'(count), 32'd4);
    checkOutput("t5_ready_lag", 32'(ready), 32'd0);
    tick();
    checkOutput("t5_ready_up", 32'(ready), 32'd1);
    readSample();
    checkOutput("t5_count3", 32'(count), 32'd3);
    checkOutput("t5_ready_hold", 32'(ready), 32'd1);
    tick();
    checkOutput("t5_ready_down", 32'(ready), 32'd0);
    repeat (3) readSample();
    checkOutput("t5_empty", 32'(empty), 32'd1);

    // Reset mid-sample
    thresh = 9'd1;
    for (int k = 0; k < 3; k++) begin
      pushSample(24'h500000 | 24'(k), 24'h600000 | 24'(k));
    end
    waitValid("t6_wait_valid");
    readWords(2);
    reset_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    #1;
    checkOutput("t6_rst_dout", 32'(dout), 32'h0);
    checkOutput("t6_rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("t6_rst_count", 32'(count), 32'd0);
    checkOutput("t6_rst_empty", 32'(empty), 32'd1);
    checkOutput("t6_rst_full", 32'(full), 32'd0);
    checkOutput("t6_rst_ovf", 32'(overflow), 32'd0);
    checkOutput("t6_rst_ready", 32'(ready), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.push_back(16'h6543);
    exp_q.push_back(16'h0FED);
    exp_q.push_back(16'h21CB);
    model_cnt++;
    applyStimulus(1'b1, 24'h654321, 24'h0FEDCB, 1'b0, 1'b0);
    checkOutput("t6_count_first_edge", 32'(count), 32'd1);
    applyStimulus(1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
    checkOutput("t6_valid", 32'(dout_valid), 32'd1);
    checkOutput("t6_w0_after_reset", 32'(dout), 32'h6543);
    readWords(3);
    model_cnt--;
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_sb_left", 32'(exp_q.size()), 32'd0);

    // thresh of zero keeps ready high even when empty
    thresh = 9'd0;
    tick();
    tick();
    checkOutput("thresh0_ready", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_sample_buf.md
RX_SAMPLE_BUF -- requirements
Module: rx_sample_buf

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the sample capacity (256 I/Q samples).
REQ-002 The block SHALL have parameter SAMP_BITS, default 24, giving the I and Q width per sample; 24 is the only legal value.
REQ-003 The block SHALL have port adc_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_strobe, input, 1 bit: one-cycle pulse marking a valid decimated sample.
REQ-006 The block SHALL have ports in_i and in_q, input, SAMP_BITS each: signed I/Q sample, valid with in_strobe.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous flush pulse.
REQ-008 The block SHALL have port rd_word, input, 1 bit: one-cycle pulse consuming the current output word.
REQ-009 The block SHALL have port thresh, input, DEPTH_LOG2+1 bits: fill level for ready.
REQ-010 The block SHALL have port dout, output, 16 bits: current output word.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: dout holds a real word.
REQ-012 The block SHALL have port count, output, DEPTH_LOG2+1 bits: samples stored.
REQ-013 The block SHALL have ports full, empty, overflow and ready, output, 1 bit each.

Function
REQ-014 The block SHALL store samples in a first-in-first-out buffer holding 2^DEPTH_LOG2 entries of {I,Q} (48 bits each), with read and write pointers that wrap modulo the depth.
REQ-015 On in_strobe with full low, the block SHALL write {in_i,in_q} at the write pointer and advance that pointer.
REQ-016 On in_strobe with full high, the block SHALL drop the sample, set overflow (sticky until clear or reset) and leave the pointers and count unchanged.
REQ-017 The word sequencer SHALL have states W0, W1 and W2 and SHALL output the head sample as: W0 dout = I[23:8]; W1 dout = Q[23:8]; W2 dout = {I[7:0],Q[7:0]}.
REQ-018 rd_word with dout_valid high SHALL advance the sequencer W0->W1->W2; in W2 it SHALL return to W0, pop the head and advance the read pointer.
REQ-019 rd_word with dout_valid low SHALL be ignored, with no state or pointer change.
REQ-020 Buffer reads SHALL be registered: after a pop, dout_valid SHALL be low for exactly one cycle (REFILL), then high with the new head's W0 word if the buffer is non-empty.
REQ-021 After a write into an empty buffer, dout_valid SHALL rise on the second cycle after the in_strobe cycle.
REQ-022 When dout_valid is low, dout SHALL be 16'h0000.
REQ-023 When a push and a pop fall in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 A push into a full buffer in the same cycle as a pop SHALL be dropped as in REQ-016, because full is evaluated before the pop.
REQ-025 count SHALL update the cycle after the event; empty = (count==0); full = (count==2^DEPTH_LOG2).
REQ-026 ready SHALL be a registered copy of (count >= thresh); with thresh==0 it SHALL be continuously high.
REQ-027 clear SHALL have priority over in_strobe and rd_word in the same cycle: it zeroes both pointers and count, resets the sequencer to W0, clears overflow, and any coincident sample is discarded.

Reset
REQ-028 While reset_n is low, the block SHALL hold: dout=0, dout_valid=0, count=0, empty=1, full=0, overflow=0, ready=0, sequencer W0, pointers 0.
REQ-029 Reset asserted mid-sequence SHALL abandon the partial sample; buffer RAM contents need not be cleared.
REQ-030 Reset release SHALL be synchronous to adc_clk, and the block SHALL accept in_strobe from the first edge after release.

Structure
REQ-031 SAMP_BITS default, the word-packing field positions and the W0/W1/W2 encodings SHALL reside in the shared header kiwi.vh, alongside RXO_BITS.
REQ-032 Storage SHALL be a separate sub-module rx_sample_ram: a simple dual-port RAM, 48 bits by 2^DEPTH_LOG2, one write port, one registered read port, no reset.
REQ-033 Pointers, count, the sequencer and the flags SHALL reside in rx_sample_buf.

Verification
REQ-034 The bench SHALL push one sample I=24'h123456, Q=24'hABCDEF, wait 2 cycles, then issue 3 rd_word; dout SHALL read 16'h1234, 16'hABCD, 16'h56EF, then dout_valid SHALL go 0 and empty SHALL go 1.
REQ-035 The bench SHALL push 257 samples with DEPTH_LOG2=8 and no reads; the result SHALL be count=256, full=1, overflow=1, and the 257th sample absent on readback.
REQ-036 The bench SHALL hold a full buffer, then assert in_strobe and a W2 rd_word together; count SHALL stay 255 after the pop, the new sample SHALL be dropped and overflow SHALL be set.
REQ-037 The bench SHALL fill 10 samples, then assert clear with in_strobe; count SHALL be 0, empty=1, overflow=0, and dout_valid SHALL be 0 on the next cycle.
REQ-038 The bench SHALL set thresh=4, push 4 samples, then read one full sample; ready SHALL go 1 the cycle after count reaches 4 and 0 after count drops to 3.
REQ-039 The bench SHALL assert reset_n low after W1 of sample 0, with 3 samples stored; all outputs SHALL take their reset values immediately, and a new push SHALL read back from W0.
